mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (IF) and load/store (LS) in the RV32I pipeline.
- Decides which requester owns the port and captures that request's fields.
- Drives the port-select line that steers the 2:1 address/data muxes in front of memory.
- Returns completed responses to their owner. LS has priority; a streak limit prevents IF starvation.

---
 rtl/rv_core_pkg.sv | 14 +
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared core definitions: memory-port arbiter states and the port-select
// encoding used by the address/data muxes in front of the unified memory.
package rv_core_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      LS_BUSY = 2'd2
   } arb_state_t;

   localparam logic PORT_SEL_IF = 1'b0;
   localparam logic PORT_SEL_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch and load/store, with LS
// priority bounded by a streak limit so a waiting fetch is never starved.
module mem_port_arbiter
   import rv_core_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              port_sel
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

   arb_state_t state;
   logic [3:0] streak;
   logic       ls_wins;

   // LS yields only when fetch is waiting and LS has used up its streak.
   always_comb begin
      ls_wins = ls_req && !(if_req && (streak == STREAK_MAX));
      ls_gnt  = (state == IDLE) && ls_wins;
      if_gnt  = (state == IDLE) && !ls_wins && if_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         streak    <= '0;
         port_sel  <= PORT_SEL_IF;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (ls_gnt) begin
                  state     <= LS_BUSY;
                  port_sel  <= PORT_SEL_LS;
                  mem_req   <= 1'b1;
                  mem_we    <= ls_we;
                  mem_be    <= ls_be;
                  mem_addr  <= ls_addr;
                  mem_wdata <= ls_wdata;
                  if (!if_req)
                     streak <= '0;
                  else if (streak != STREAK_MAX)
                     streak <= streak + 4'd1;
               end else if (if_gnt) begin
                  state     <= IF_BUSY;
                  port_sel  <= PORT_SEL_IF;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= 4'hF;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  streak    <= '0;
               end else begin
                  // No grant here implies if_req is low.
                  streak <= '0;
               end
            end
            IF_BUSY: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  if_rvalid <= 1'b1;
                  if_rdata  <= mem_rdata;
               end
            end
            LS_BUSY: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  ls_rvalid <= 1'b1;
                  ls_rdata  <= mem_we ? '0 : mem_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and responses are
// queued at issue time and consumed by a monitor as the DUT produces them.
module tb_mem_port_arbiter;
   import rv_core_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [3:0]  ls_be;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        port_sel;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .port_sel(port_sel)
   );

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gnt_t;

   typedef struct {
      logic        is_ls;
      logic [31:0] data;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];
   int   n_pass = 0;
   int   n_chk  = 0;
   int   lat    = 0;
   int   cnt    = 0;
   logic idle_ready = 1'b0;
   logic pend = 1'b0;
   gnt_t cur;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'h0050_0093;
         32'h0000_1000: return 32'hDEAD_BEEF;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic exp_if(input logic [31:0] a);
      gq.push_back('{1'b0, 1'b0, 4'hF, a, 32'h0});
      rq.push_back('{1'b0, mem_val(a)});
   endtask

   task automatic exp_ls(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd);
      gq.push_back('{1'b1, we, be, a, wd});
      rq.push_back('{1'b1, we ? 32'h0 : mem_val(a)});
   endtask

   // Requester tasks start at a negedge, hold fields until granted, and return
   // at the negedge after the grant with req still high.
   task automatic do_if(input logic [31:0] a);
      int t = 0;
      if_req  = 1'b1;
      if_addr = a;
      #1;
      while (!if_gnt && t < 200) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 200) chk("if_gnt_timeout", 160'd0, 160'd1);
      @(negedge clk);
   endtask

   task automatic do_ls(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd);
      int t = 0;
      ls_req   = 1'b1;
      ls_we    = we;
      ls_be    = be;
      ls_addr  = a;
      ls_wdata = wd;
      #1;
      while (!ls_gnt && t < 200) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 200) chk("ls_gnt_timeout", 160'd0, 160'd1);
      @(negedge clk);
   endtask

   task automatic drain();
      int t = 0;
      while ((gq.size() != 0 || rq.size() != 0) && t < 200) begin
         @(negedge clk); t++;
      end
      if (t >= 200) chk("drain_timeout", 160'(gq.size() + rq.size()), 160'd0);
      @(negedge clk);
   endtask

   // Memory model: answers lat cycles into an access; stores return all-ones.
   always @(negedge clk) begin
      if (mem_req) begin
         if (cnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem_we ? 32'hFFFF_FFFF : mem_val(mem_addr);
            cnt = 0;
         end else begin
            mem_ready = 1'b0;
            cnt++;
         end
      end else begin
         mem_ready = idle_ready;
         mem_rdata = 32'h1234_5678;
         cnt = 0;
      end
   end

   always @(negedge clk) begin
      #2;
      if (pend) begin
         chk("port_sel", 160'(port_sel), 160'(cur.is_ls));
         chk("mem_req",  160'(mem_req),  160'd1);
         chk("mem_ctl",  {mem_we, mem_be, mem_addr}, {cur.we, cur.be, cur.addr});
         if (cur.is_ls) chk("mem_wdata", 160'(mem_wdata), 160'(cur.wdata));
         pend = 1'b0;
      end
      if (if_gnt || ls_gnt) begin
         if (gq.size() == 0) begin
            chk("unexpected_gnt", {if_gnt, ls_gnt}, 160'd0);
         end else begin
            cur = gq.pop_front();
            chk("gnt_owner", {if_gnt, ls_gnt}, cur.is_ls ? 160'b01 : 160'b10);
            pend = 1'b1;
         end
      end
      if (if_rvalid || ls_rvalid) begin
         if (rq.size() == 0) begin
            chk("unexpected_rvalid", {if_rvalid, ls_rvalid}, 160'd0);
         end else begin
            rsp_t r;
            r = rq.pop_front();
            chk("rvalid_owner", {if_rvalid, ls_rvalid}, r.is_ls ? 160'b01 : 160'b10);
            chk("rdata", r.is_ls ? 160'(ls_rdata) : 160'(if_rdata), 160'(r.data));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("reset_outs", {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                            mem_req, mem_we, mem_be, port_sel}, 160'd0);
         chk("reset_mem", {mem_addr, mem_wdata}, 160'd0);
         chk("reset_state", 160'(dut.state), 160'(IDLE));
      end

      idle_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("idle_ready_rvalid", {if_rvalid, ls_rvalid}, 160'd0);
      end
      idle_ready = 1'b0;
      @(negedge clk); #1;
      chk("idle_ready_rvalid", {if_rvalid, ls_rvalid}, 160'd0);

      // Single fetch.
      lat = 2;
      @(negedge clk);
      exp_if(32'h40);
      do_if(32'h40);
      if_req = 1'b0;
      drain();
      repeat (2) @(negedge clk);
      #1 chk("if_rdata_hold", 160'(if_rdata), 160'h0050_0093);
      @(negedge clk);

      // Simultaneous requests: LS first.
      lat = 1;
      exp_ls(1'b0, 4'hF, 32'h1000, 32'h0);
      exp_if(32'h80);
      fork
         begin do_ls(1'b0, 4'hF, 32'h1000, 32'h0); ls_req = 1'b0; end
         begin do_if(32'h80); if_req = 1'b0; end
      join
      drain();
      #1 chk("ls_rdata_hold", 160'(ls_rdata), 160'hDEAD_BEEF);
      @(negedge clk);

      // Store.
      lat = 0;
      exp_ls(1'b1, 4'h3, 32'h2004, 32'h0000_ABCD);
      do_ls(1'b1, 4'h3, 32'h2004, 32'h0000_ABCD);
      ls_req = 1'b0;
      drain();

      // Starvation guard: L L L L I L L I.
      for (int i = 0; i < 4; i++) exp_ls(1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0);
      exp_if(32'h100);
      exp_ls(1'b0, 4'hF, 32'h3010, 32'h0);
      exp_ls(1'b0, 4'hF, 32'h3014, 32'h0);
      exp_if(32'h104);
      fork
         begin
            for (int i = 0; i < 6; i++) do_ls(1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0);
            ls_req = 1'b0;
         end
         begin
            do_if(32'h100);
            do_if(32'h104);
            if_req = 1'b0;
         end
      join
      drain();

      // Reset mid-access: grant expected, response abandoned.
      lat = 20;
      gq.push_back('{1'b1, 1'b0, 4'hF, 32'h4000, 32'h0});
      do_ls(1'b0, 4'hF, 32'h4000, 32'h0);
      ls_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mem_req", 160'(mem_req), 160'd0);
      chk("rst_port_sel", 160'(port_sel), 160'd0);
      chk("rst_state", 160'(dut.state), 160'(IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("post_rst_rvalid", {if_rvalid, ls_rvalid, mem_req}, 160'd0);
      end

      exp_ls(1'b0, 4'hF, 32'h5000, 32'h0);
      exp_if(32'h200);
      fork
         begin do_ls(1'b0, 4'hF, 32'h5000, 32'h0); ls_req = 1'b0; end
         begin do_if(32'h200); if_req = 1'b0; end
      join
      drain();

      chk("queues_empty", 160'(gq.size() + rq.size()), 160'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
